// File: rtl/tofpet_interface_avalon_if_pkg.sv
// Shared address map, fixed read-back word and status bit positions for the
// TOFPET Avalon-MM register bridge.
package tofpet_interface_avalon_if_pkg;

  localparam logic [3:0] ADDR_FIFO0     = 4'h0;
  localparam logic [3:0] ADDR_FIFO1     = 4'h1;
  localparam logic [3:0] ADDR_FIFO2     = 4'h2;
  localparam logic [3:0] ADDR_FIFO3     = 4'h3;
  localparam logic [3:0] ADDR_FIFO4     = 4'h4;
  localparam logic [3:0] ADDR_FIFO5     = 4'h5;
  localparam logic [3:0] ADDR_FIFO_STAT = 4'h6;
  localparam logic [3:0] ADDR_DUMMY     = 4'h7;
  localparam logic [3:0] ADDR_CTRL_OUT  = 4'h8;
  localparam logic [3:0] ADDR_CTRL_IN   = 4'h9;
  localparam logic [3:0] ADDR_NBIT      = 4'hA;
  localparam logic [3:0] ADDR_CMD       = 4'hB;
  localparam logic [3:0] ADDR_STATUS    = 4'hC;
  localparam logic [3:0] ADDR_UW01      = 4'hD;
  localparam logic [3:0] ADDR_UW23      = 4'hE;
  localparam logic [3:0] ADDR_UW45      = 4'hF;

  localparam logic [31:0] DUMMY_WORD = 32'hF1CA_CAFE;

  localparam int STAT_CTRL_IN_EMPTY  = 0;
  localparam int STAT_CTRL_IN_FULL   = 1;
  localparam int STAT_CTRL_OUT_EMPTY = 2;
  localparam int STAT_CTRL_OUT_FULL  = 3;
  localparam int STAT_RW_RUNNING     = 30;

  function automatic logic [31:0] pack_used_words(input logic [10:0] hi, input logic [10:0] lo);
    return {5'b0, hi, 5'b0, lo};
  endfunction

endpackage

// File: rtl/tofpet_interface_avalon_if.sv
// Avalon-MM slave exposing the TOFPET data FIFOs, control FIFO pair, config
// registers and status word. Every access acts only in its first cycle.
module tofpet_interface_avalon_if
  import tofpet_interface_avalon_if_pkg::*;
(
  input  logic        CK,
  input  logic        RESETb,
  input  logic [31:0] DATA_OUT0,
  input  logic [31:0] DATA_OUT1,
  input  logic [31:0] DATA_OUT2,
  input  logic [31:0] DATA_OUT3,
  input  logic [31:0] DATA_OUT4,
  input  logic [31:0] DATA_OUT5,
  input  logic        EMPTY0, EMPTY1, EMPTY2, EMPTY3, EMPTY4, EMPTY5,
  input  logic        FULL0, FULL1, FULL2, FULL3, FULL4, FULL5,
  output logic        READ0, READ1, READ2, READ3, READ4, READ5,
  input  logic [10:0] USED_WORDS0,
  input  logic [10:0] USED_WORDS1,
  input  logic [10:0] USED_WORDS2,
  input  logic [10:0] USED_WORDS3,
  input  logic [10:0] USED_WORDS4,
  input  logic [10:0] USED_WORDS5,
  input  logic [31:0] CTRL_FIFO_OUT,
  output logic        CTRL_FIFO_OUT_RE,
  output logic [31:0] CTRL_FIFO_IN,
  output logic        CTRL_FIFO_IN_WE,
  output logic [31:0] NBIT_INOUT,
  output logic [31:0] COMMAND,
  input  logic [31:0] STATUS_WORD,
  input  logic [3:0]  avalon_addr,
  input  logic [31:0] avalon_data_in,
  output logic [31:0] avalon_data_out,
  input  logic        avalon_cs,
  input  logic        avalon_readn,
  input  logic        avalon_writen
);

  logic        rd_acc, wr_acc;
  logic        rd_acc_q, wr_acc_q;
  logic        rd_first, wr_first;
  logic [5:0]  empty_vec, full_vec, read_vec;
  logic [31:0] rd_value;
  logic [31:0] nbit_reg, command_reg, ctrl_in_reg, data_out_reg;
  logic        ctrl_we_reg;

  assign rd_acc = avalon_cs & ~avalon_readn;
  assign wr_acc = avalon_cs & ~avalon_writen;

  // Gating with RESETb makes every strobe drop the instant reset asserts.
  assign rd_first = rd_acc & ~rd_acc_q & RESETb;
  assign wr_first = wr_acc & ~wr_acc_q & RESETb;

  assign empty_vec = {EMPTY5, EMPTY4, EMPTY3, EMPTY2, EMPTY1, EMPTY0};
  assign full_vec  = {FULL5, FULL4, FULL3, FULL2, FULL1, FULL0};

  // Pops coincide with the capture edge so the show-ahead head is sampled first.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pop
      assign read_vec[gi] = rd_first & (avalon_addr == 4'(gi)) & ~empty_vec[gi];
    end
  endgenerate

  assign {READ5, READ4, READ3, READ2, READ1, READ0} = read_vec;

  assign CTRL_FIFO_OUT_RE = rd_first & (avalon_addr == ADDR_CTRL_OUT)
                          & ~STATUS_WORD[STAT_CTRL_OUT_EMPTY];

  always_comb begin
    rd_value = 32'b0;
    case (avalon_addr)
      ADDR_FIFO0:     rd_value = DATA_OUT0;
      ADDR_FIFO1:     rd_value = DATA_OUT1;
      ADDR_FIFO2:     rd_value = DATA_OUT2;
      ADDR_FIFO3:     rd_value = DATA_OUT3;
      ADDR_FIFO4:     rd_value = DATA_OUT4;
      ADDR_FIFO5:     rd_value = DATA_OUT5;
      ADDR_FIFO_STAT: rd_value = {16'b0, 2'b0, full_vec, 2'b0, empty_vec};
      ADDR_DUMMY:     rd_value = DUMMY_WORD;
      ADDR_CTRL_OUT:  rd_value = CTRL_FIFO_OUT;
      ADDR_CTRL_IN:   rd_value = 32'b0;
      ADDR_NBIT:      rd_value = nbit_reg;
      ADDR_CMD:       rd_value = command_reg;
      ADDR_STATUS:    rd_value = STATUS_WORD;
      ADDR_UW01:      rd_value = pack_used_words(USED_WORDS1, USED_WORDS0);
      ADDR_UW23:      rd_value = pack_used_words(USED_WORDS3, USED_WORDS2);
      ADDR_UW45:      rd_value = pack_used_words(USED_WORDS5, USED_WORDS4);
      default:        rd_value = 32'b0;
    endcase
  end

  always_ff @(posedge CK or negedge RESETb) begin
    if (!RESETb) begin
      rd_acc_q     <= 1'b0;
      wr_acc_q     <= 1'b0;
      nbit_reg     <= 32'b0;
      command_reg  <= 32'b0;
      ctrl_in_reg  <= 32'b0;
      ctrl_we_reg  <= 1'b0;
      data_out_reg <= 32'b0;
    end else begin
      rd_acc_q    <= rd_acc;
      wr_acc_q    <= wr_acc;
      ctrl_we_reg <= 1'b0;
      if (rd_first) begin
        data_out_reg <= rd_value;
      end
      // Register reads above use the pre-write value when both access types coincide.
      if (wr_first) begin
        case (avalon_addr)
          ADDR_NBIT: nbit_reg    <= avalon_data_in;
          ADDR_CMD:  command_reg <= avalon_data_in;
          ADDR_CTRL_IN: begin
            if (!STATUS_WORD[STAT_CTRL_IN_FULL]) begin
              ctrl_in_reg <= avalon_data_in;
              ctrl_we_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign NBIT_INOUT      = nbit_reg;
  assign COMMAND         = command_reg;
  assign CTRL_FIFO_IN    = ctrl_in_reg;
  assign CTRL_FIFO_IN_WE = ctrl_we_reg;
  assign avalon_data_out = data_out_reg;

endmodule

// File: tb/tb_tofpet_interface_avalon_if.sv
// Randomized and directed bench for the TOFPET Avalon bridge, checked every
// cycle against a transaction-level model of the register map.
module tb_tofpet_interface_avalon_if;

  logic        ck = 1'b0;
  logic        resetb = 1'b0;
  logic [31:0] fifo_data [6];
  logic [5:0]  empty = 6'h3F;
  logic [5:0]  full = 6'h0;
  logic [5:0]  read_s;
  logic [10:0] used [6];
  logic [31:0] ctrl_out = 32'h0;
  logic        ctrl_re;
  logic [31:0] ctrl_in;
  logic        ctrl_we;
  logic [31:0] nbit, cmd;
  logic [31:0] status = 32'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        cs = 1'b0, readn = 1'b1, writen = 1'b1;

  int checks = 0;
  int errors = 0;

  // model state
  logic [5:0]  exp_read = 6'h0;
  logic        exp_re = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_cfi = 32'h0, exp_nbit = 32'h0, exp_cmd = 32'h0, exp_dout = 32'h0;
  bit          cmp_en = 1'b0;
  int          we_cnt = 0, re_cnt = 0;
  int          rd_cnt [6];
  logic [31:0] last_cfi = 32'h0;

  always #5 ck = ~ck;

  tofpet_interface_avalon_if dut (
    .CK(ck), .RESETb(resetb),
    .DATA_OUT0(fifo_data[0]), .DATA_OUT1(fifo_data[1]), .DATA_OUT2(fifo_data[2]),
    .DATA_OUT3(fifo_data[3]), .DATA_OUT4(fifo_data[4]), .DATA_OUT5(fifo_data[5]),
    .EMPTY0(empty[0]), .EMPTY1(empty[1]), .EMPTY2(empty[2]),
    .EMPTY3(empty[3]), .EMPTY4(empty[4]), .EMPTY5(empty[5]),
    .FULL0(full[0]), .FULL1(full[1]), .FULL2(full[2]),
    .FULL3(full[3]), .FULL4(full[4]), .FULL5(full[5]),
    .READ0(read_s[0]), .READ1(read_s[1]), .READ2(read_s[2]),
    .READ3(read_s[3]), .READ4(read_s[4]), .READ5(read_s[5]),
    .USED_WORDS0(used[0]), .USED_WORDS1(used[1]), .USED_WORDS2(used[2]),
    .USED_WORDS3(used[3]), .USED_WORDS4(used[4]), .USED_WORDS5(used[5]),
    .CTRL_FIFO_OUT(ctrl_out), .CTRL_FIFO_OUT_RE(ctrl_re),
    .CTRL_FIFO_IN(ctrl_in), .CTRL_FIFO_IN_WE(ctrl_we),
    .NBIT_INOUT(nbit), .COMMAND(cmd), .STATUS_WORD(status),
    .avalon_addr(addr), .avalon_data_in(din), .avalon_data_out(dout),
    .avalon_cs(cs), .avalon_readn(readn), .avalon_writen(writen)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Register map seen by the host, evaluated against the current model state.
  function automatic logic [31:0] model_read(input logic [3:0] a);
    int ia = int'(a);
    int k;
    if (ia < 6) return fifo_data[ia];
    case (ia)
      6:  return {18'b0, full, 2'b0, empty};
      7:  return 32'hF1CA_CAFE;
      8:  return ctrl_out;
      9:  return 32'h0;
      10: return exp_nbit;
      11: return exp_cmd;
      12: return status;
      default: begin
        k = ia - 13;
        return {5'b0, used[2*k+1], 5'b0, used[2*k]};
      end
    endcase
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 6; i++) begin
      fifo_data[i] = $urandom;
      used[i] = 11'($urandom);
    end
    empty = 6'($urandom);
    full = 6'($urandom);
    ctrl_out = $urandom;
    status = $urandom;
  endtask

  // One host access held for 'hold' cycles; the model applies its effects once.
  task automatic access(input bit do_rd, input bit do_wr, input logic [3:0] a,
                        input logic [31:0] wd, input int hold, input bit rnd);
    logic [31:0] rv;
    if (rnd) randomize_inputs();
    cs = 1'b1; readn = ~do_rd; writen = ~do_wr; addr = a; din = wd;
    rv = model_read(a);
    exp_read = 6'h0;
    exp_re = 1'b0;
    if (do_rd && int'(a) < 6) exp_read[int'(a)] = ~empty[int'(a)];
    if (do_rd && a == 4'h8) exp_re = ~status[2];
    @(posedge ck); #1;
    exp_read = 6'h0;
    exp_re = 1'b0;
    if (do_rd) exp_dout = rv;
    if (do_wr) begin
      if (a == 4'hA) exp_nbit = wd;
      else if (a == 4'hB) exp_cmd = wd;
      else if (a == 4'h9 && !status[1]) begin
        exp_cfi = wd;
        exp_we = 1'b1;
      end
    end
    for (int i = 1; i < hold; i++) begin
      if (rnd) randomize_inputs();
      @(posedge ck); #1;
      exp_we = 1'b0;
    end
    cs = 1'b0; readn = 1'b1; writen = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck); #1;
      exp_we = 1'b0;
      readn = 1'($urandom);
    end
    readn = 1'b1;
  endtask

  task automatic clear_counts();
    we_cnt = 0;
    re_cnt = 0;
    for (int i = 0; i < 6; i++) rd_cnt[i] = 0;
  endtask

  // Compare process: all outputs are checked on every falling edge.
  always @(negedge ck) begin
    if (cmp_en) begin
      chk("read_strobes", {26'b0, read_s}, {26'b0, exp_read});
      chk("ctrl_out_re", {31'b0, ctrl_re}, {31'b0, exp_re});
      chk("ctrl_in_we", {31'b0, ctrl_we}, {31'b0, exp_we});
      if (exp_we) chk("ctrl_in_data", ctrl_in, exp_cfi);
      chk("nbit", nbit, exp_nbit);
      chk("command", cmd, exp_cmd);
      chk("data_out", dout, exp_dout);
    end
    if (ctrl_we === 1'b1) begin
      we_cnt++;
      last_cfi = ctrl_in;
    end
    if (ctrl_re === 1'b1) re_cnt++;
    for (int i = 0; i < 6; i++) if (read_s[i] === 1'b1) rd_cnt[i]++;
  end

  initial begin
    int others;
    for (int i = 0; i < 6; i++) begin
      fifo_data[i] = 32'h0;
      used[i] = 11'h0;
      rd_cnt[i] = 0;
    end
    repeat (3) @(posedge ck);
    #1;
    chk("reset_dout", dout, 32'h0);
    chk("reset_nbit", nbit, 32'h0);
    chk("reset_cmd", cmd, 32'h0);
    chk("reset_strobes", {26'b0, read_s, ctrl_re, ctrl_we, ctrl_in[0]}, 32'h0);
    resetb = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    access(1, 0, 4'h7, 32'h0, 1, 0); idle(1);
    chk("dummy_lit", dout, 32'hF1CA_CAFE);
    access(1, 0, 4'hA, 32'h0, 1, 0); idle(1);
    chk("nbit_rst_lit", dout, 32'h0);
    access(1, 0, 4'hB, 32'h0, 1, 0); idle(1);
    chk("cmd_rst_lit", dout, 32'h0);

    access(0, 1, 4'hB, 32'h0210_0004, 1, 0);
    chk("cmd_wr_lit", cmd, 32'h0210_0004);
    idle(1);
    access(1, 0, 4'hB, 32'h0, 2, 0); idle(1);
    chk("cmd_rd_lit", dout, 32'h0210_0004);

    status = 32'h0; clear_counts();
    access(0, 1, 4'h9, 32'h8820_8203, 3, 0); idle(2);
    chk("we_once", we_cnt, 1);
    chk("cfi_lit", last_cfi, 32'h8820_8203);
    status = 32'h2; clear_counts();
    access(0, 1, 4'h9, 32'h1111_2222, 3, 0); idle(2);
    chk("we_full_none", we_cnt, 0);

    ctrl_out = 32'h9A70_0000; status = 32'h0; clear_counts();
    access(1, 0, 4'h8, 32'h0, 2, 0); idle(1);
    chk("ctrl_out_lit", dout, 32'h9A70_0000);
    chk("re_once", re_cnt, 1);
    status = 32'h4; clear_counts();
    access(1, 0, 4'h8, 32'h0, 2, 0); idle(1);
    chk("re_empty_none", re_cnt, 0);

    empty = 6'h00; fifo_data[3] = 32'h1234_5678; clear_counts();
    access(1, 0, 4'h3, 32'h0, 2, 0); idle(1);
    others = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[4] + rd_cnt[5];
    chk("fifo3_lit", dout, 32'h1234_5678);
    chk("read3_once", rd_cnt[3], 1);
    chk("read_others", others, 0);
    empty = 6'h08; clear_counts();
    access(1, 0, 4'h3, 32'h0, 1, 0); idle(1);
    chk("read3_empty_none", rd_cnt[3], 0);

    used[0] = 11'd5; used[1] = 11'd2047;
    access(1, 0, 4'hD, 32'h0, 1, 0); idle(1);
    chk("uw01_lit", dout, 32'h07FF_0005);
    full = 6'h04; empty = 6'h01;
    access(1, 0, 4'h6, 32'h0, 1, 0); idle(1);
    chk("fifo_stat_lit", dout, 32'h0000_0401);

    access(0, 1, 4'hA, 32'hDEAD_BEEF, 1, 0); idle(1);
    access(1, 1, 4'hA, 32'h1111_1111, 1, 0); idle(1);
    chk("rw_pre_write_lit", dout, 32'hDEAD_BEEF);
    chk("rw_nbit_lit", nbit, 32'h1111_1111);

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      access(kind < 6 || kind == 9, kind >= 6, 4'($urandom), $urandom,
             $urandom_range(1, 3), 1);
      idle($urandom_range(1, 2));
    end

    // Reset in the middle of a popping read: strobes must vanish at once.
    empty = 6'h00;
    cs = 1'b1; readn = 1'b0; addr = 4'h0;
    exp_read = 6'h01;
    #1;
    chk("pre_reset_pop", {31'b0, read_s[0]}, 32'h1);
    resetb = 1'b0;
    exp_read = 6'h0; exp_re = 1'b0; exp_we = 1'b0;
    exp_nbit = 32'h0; exp_cmd = 32'h0; exp_dout = 32'h0;
    #1;
    chk("reset_mid_pop", {26'b0, read_s}, 32'h0);
    chk("reset_mid_dout", dout, 32'h0);
    @(posedge ck); #1;
    cs = 1'b0; readn = 1'b1;
    @(posedge ck); #1;
    resetb = 1'b1;
    idle(2);
    access(1, 0, 4'hB, 32'h0, 1, 0); idle(1);
    chk("cmd_after_reset", dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
